seq_mult16: RTL and testbench
=============================

Name: seq_mult16

Overview:
- Sequential 16x16 unsigned shift-add multiplier with a start/done handshake.
- Ain and Bin are captured once per operation; the low 16 bits of the exact 32-bit product are returned on Yout.
- Top-level compute block, driven by a controller that pulses start for several clocks and then polls done.
- Implemented as a controller FSM, a datapath (multiplicand, multiplier shift register, 32-bit accumulator, 4-bit counter) and an output register.

Parameters:
- WIDTH, 16, operand and result width. Only 16 is required to be supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level request; an operation begins when start is released (1 then 0).
- Ain  input  16  unsigned multiplicand.
- Bin  input  16  unsigned multiplier.
- Yout  output  16  registered result = (Ain*Bin) mod 2^16.
- done  output  1  high while a valid result is held on Yout.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Yout=0, done=0.
  - Accumulator, counter and operand registers are cleared.
- FSM states: IDLE, WAIT, LOAD, CALC, DONE.
- IDLE: done=0. If start=1, go to WAIT.
- WAIT: stay while start=1. When start=0, go to LOAD. A start held for any number of cycles yields exactly one operation.
- LOAD (1 cycle):
  - A_reg<=Ain, B_reg<=Bin, ACC<=0, cnt<=0.
  - Ain/Bin are sampled only here. Later input changes do not affect the running operation.
  - Go to CALC.
- CALC (exactly 16 cycles, cnt 0..15), each cycle:
  - If B_reg[0]=1, ACC<=ACC+(A_reg<<cnt), computed 32 bits wide.
  - B_reg<=B_reg>>1; cnt<=cnt+1.
  - After the cnt=15 cycle, go to DONE and load Yout<=ACC_next[15:0].
- DONE:
  - done=1; Yout holds.
  - If start=1, go to WAIT and drop done on that edge. Yout keeps the old value until the next result is written.
- Fixed latency: done rises 18 rising edges after the edge that samples start=0 in WAIT (1 LOAD + 16 CALC + 1 entry to DONE). Latency is independent of operand values.
- Arithmetic:
  - Unsigned operands.
  - Internal product is exact 32 bits; upper 16 bits are discarded.
  - No saturation; no overflow flag.
- start=1 during LOAD or CALC is ignored. After DONE, a new start is needed.
- Reset mid-operation aborts immediately: done=0, Yout=0, state IDLE.
- Zero operand: result is 0, with the same latency.
- Identical operands are fine (e.g. 65535*65535).

Test Plan:
- Reset: rst=0 at any time -> Yout=0, done=0 immediately, without waiting for a clock edge. Release rst=1 -> stays IDLE with done=0.
- Ain=127, Bin=255, start high 3 clocks then low -> done=1 exactly 18 edges after start is sampled low; Yout=32385.
- Ain=11903, Bin=2753, after reset -> Yout=959 (32768959 mod 65536), done=1.
- Ain=65535, Bin=65535 -> Yout=1 (0xFFFE0001 low half), done held high until the next start.
- Back-to-back without reset:
  - Run 127*255, then assert start in DONE -> done drops on that edge.
  - Change Ain=3, Bin=0 mid-CALC of the next operation (inputs already loaded as 5, 7) -> Yout=35, unaffected by the change.
- Reset during CALC (cnt≈8) -> done=0, Yout=0. No done ever appears until a fresh start release.

Source files
------------

// File: rtl/seq_mult16.sv
// Sequential unsigned shift-add multiplier with a start-release handshake.
// One operand bit per cycle; the result is the low WIDTH bits of the exact product.
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] Yout,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]      cnt;
    logic               last;

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        if (b_reg[0])
            acc_nx = acc + ({{WIDTH{1'b0}}, a_reg} << cnt);
        case (state)
            S_IDLE:  if (start) state_nx = S_WAIT;
            S_WAIT:  if (!start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_CALC;
            S_CALC:  if (last) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_WAIT;
            default: state_nx = S_IDLE;
        endcase
    end

    // done is registered one edge after DONE entry and clears on the same
    // edge that a new start is sampled in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            Yout  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == S_DONE) && !start;
            case (state)
                S_LOAD: begin
                    a_reg <= Ain;
                    b_reg <= Bin;
                    acc   <= '0;
                    cnt   <= '0;
                end
                S_CALC: begin
                    acc   <= acc_nx;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last)
                        Yout <= acc_nx[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
// Bench for seq_mult16: directed handshake/reset cases plus random operands
// checked against a plain-arithmetic product model.
module tb_seq_mult16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] Ain, Bin;
    logic [15:0] Yout;
    logic        done;

    int tests = 0;
    int fails = 0;

    seq_mult16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Ain  (Ain),
        .Bin  (Bin),
        .Yout (Yout),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[15:0];
    endfunction

    // Hold start for 'hold' cycles, release, then count edges until done.
    // If mid_at > 0, Ain/Bin are overwritten that many edges after release.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input int mid_at,
                          input logic [15:0] ma, input logic [15:0] mb);
        int n;
        logic [15:0] exp;
        exp = model(a, b);
        @(negedge clk);
        Ain = a; Bin = b; start = 1'b1;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(posedge clk);                 // edge that samples start=0
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == mid_at) begin
                Ain = ma; Bin = mb;
            end
        end while (!done && n < 40);
        chk({tag, "_latency"}, n, 18);
        chk({tag, "_yout"}, Yout, exp);
    endtask

    initial begin
        int n;
        logic seen;
        logic [15:0] ra, rb;
        rst = 1'b0; start = 1'b0; Ain = '0; Bin = '0;
        #1;
        chk("reset_yout", Yout, 0);
        chk("reset_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_done", done, 0);

        run_op("m127x255", 16'd127, 16'd255, 3, 0, 0, 0);
        chk("m127x255_exact", Yout, 32385);
        run_op("m11903x2753", 16'd11903, 16'd2753, 1, 0, 0, 0);
        chk("m11903x2753_exact", Yout, 959);
        run_op("mffff", 16'hFFFF, 16'hFFFF, 2, 0, 0, 0);
        chk("mffff_exact", Yout, 1);
        repeat (6) @(negedge clk);
        chk("done_hold", done, 1);
        chk("yout_hold", Yout, 1);

        run_op("m127x255b", 16'd127, 16'd255, 1, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        chk("done_drop", done, 0);
        chk("yout_keep", Yout, 32385);
        @(negedge clk);
        Ain = 16'd5; Bin = 16'd7;
        start = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); n++; #1;
            if (n == 6) begin Ain = 16'd3; Bin = 16'd0; end
        end while (!done && n < 40);
        chk("b2b_latency", n, 18);
        chk("b2b_yout", Yout, 35);

        run_op("mzero", 16'd0, 16'd4321, 1, 5, 16'd9, 16'd9);
        run_op("long_start", 16'd300, 16'd400, 9, 0, 0, 0);
        repeat (25) @(negedge clk);
        chk("single_op", done, 1);

        // abort mid-CALC: reset lands between edges, outputs clear at once
        run_op("pre_abort", 16'd127, 16'd255, 1, 0, 0, 0);
        @(negedge clk);
        Ain = 16'd1000; Bin = 16'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_yout", Yout, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_yout_idle", Yout, 0);

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
